// File: rtl/uart_tx_periph.sv
// uart_tx_periph: bus-mapped 8N1 UART transmitter with TX FIFO.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   i_we         : store strobe (one cycle per store)
//   i_addr       : word index 0=DATA 1=STATUS 2=DIV 3=reserved
//   i_data       : store data
//   o_data       : combinational read data for i_addr
//   o_tx         : registered serial line, idles high
//   o_busy       : registered, FSM active or FIFO non-empty
module uart_tx_periph #(
  parameter int FIFO_AW     = 3,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT =
    (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [15:0]        div_q, wdiv_q, baud_q;
  logic [7:0]         shift_q;
  logic [2:0]         bit_q;
  logic               tx_q, tx_d;
  logic               busy_q, ovf_q;
  logic               full, empty;
  logic               wr_data, wr_stat, wr_div;
  logic               push, pop, bit_end;
  logic [31:0]        status, rdata;
  logic               unused_data;

  assign full    = cnt_q == FULL_CNT;
  assign empty   = cnt_q == '0;
  assign wr_data = i_we && i_addr == 2'd0;
  assign wr_stat = i_we && i_addr == 2'd1;
  assign wr_div  = i_we && i_addr == 2'd2;
  // full is taken from the registered count, so a pop
  // in the same cycle never makes room for this push
  assign push    = wr_data && !full;
  assign bit_end = baud_q == wdiv_q;
  assign unused_data = ^i_data[31:16];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // tx_d is the line level for the state being entered,
  // so the registered pin lines up with the state
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data[7:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      div_q    <= 16'(DEFAULT_DIV);
      wdiv_q   <= '0;
      baud_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE) || (cnt_d != '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_div) div_q <= i_data[15:0];
      if (wr_stat)
        ovf_q <= 1'b0;
      else if (wr_data && full)
        ovf_q <= 1'b1;
      // divisor is latched here so DIV writes only
      // take effect from the next frame
      if (pop) begin
        shift_q <= mem_q[rd_ptr_q];
        wdiv_q  <= div_q;
        baud_q  <= '0;
      end else if (state_q != S_IDLE) begin
        baud_q <= bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          unique case (state_q)
            S_START: bit_q <= '0;
            S_DATA: begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign status = {
    {(27-FIFO_AW){1'b0}},
    cnt_q,
    ovf_q,
    empty,
    full,
    state_q != S_IDLE
  };

  always_comb begin
    rdata = '0;
    unique case (i_addr)
      2'd1:    rdata = status;
      2'd2:    rdata = {16'b0, div_q};
      default: rdata = '0;
    endcase
  end

  assign o_data = rdata;
  assign o_tx   = tx_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed bench for uart_tx_periph.
// Drives and samples on the falling clock edge.
module tb_uart_tx_periph;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [7:0] bytes_v [10];

  uart_tx_periph #(
    .FIFO_AW(3),
    .DEFAULT_DIV(433)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_we  (we),
    .i_addr(addr),
    .i_data(wdata),
    .o_data(rdata),
    .o_tx  (tx),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input string tag,
                    input logic [1:0] a,
                    input logic [31:0] e);
    addr = a;
    #1;
    chk(tag, rdata, e);
  endtask

  // checks one frame cycle by cycle; the first `skip`
  // cycles are already past when this is called
  task automatic frame(input string tag,
                       input logic [7:0] b,
                       input int div,
                       input int skip);
    int idx;
    int bad;
    int n;
    logic e;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)
        e = 1'b0;
      else if (k == 9)
        e = 1'b1;
      else
        e = b[3'(k-1)];
      bad = 0;
      n = 0;
      for (int c = 0; c <= div; c++) begin
        if (idx >= skip) begin
          n++;
          if (tx !== e) bad++;
          @(negedge clk);
        end
        idx++;
      end
      if (n > 0)
        chk($sformatf("%s bit%0d badcyc", tag, k),
            32'(bad), 32'd0);
    end
  endtask

  // one idle-high cycle, then the next frame
  task automatic next_frame(input string tag,
                            input logic [7:0] b,
                            input int div);
    chk({tag, " gap"}, 32'(tx), 32'd1);
    @(negedge clk);
    frame(tag, b, div, 0);
  endtask

  initial begin
    int lows;
    n_cmp = 0;
    n_err = 0;
    bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A,
                8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    rst   = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    rd("rst data", 2'd0, 32'd0);
    rd("rst status", 2'd1, 32'h4);
    rd("rst div", 2'd2, 32'd433);
    rd("rst rsvd", 2'd3, 32'd0);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);

    // 0xA5 with 4-cycle bits
    wr(2'd2, 32'd3);
    rd("div3", 2'd2, 32'd3);
    wr(2'd0, 32'hA5);
    chk("a5 lat tx", 32'(tx), 32'd1);
    chk("a5 busy", 32'(busy), 32'd1);
    @(negedge clk);
    frame("a5", 8'hA5, 3, 0);
    chk("a5 end busy", 32'(busy), 32'd0);
    chk("a5 end tx", 32'(tx), 32'd1);
    rd("a5 end status", 2'd1, 32'h4);

    // back-to-back 1-cycle-bit frames
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h55);
    wr(2'd0, 32'h0F);
    rd("b2b status", 2'd1, 32'h11);
    frame("55", 8'h55, 0, 0);
    rd("b2b idle status", 2'd1, 32'h10);
    next_frame("0f", 8'h0F, 0);
    chk("b2b end busy", 32'(busy), 32'd0);

    // overflow: 9 accepted, 10th dropped
    wr(2'd2, 32'd3);
    for (int i = 0; i < 10; i++)
      wr(2'd0, 32'(bytes_v[i]));
    rd("ovf status", 2'd1, 32'h8B);
    wr(2'd1, 32'd0);
    rd("ovf clr status", 2'd1, 32'h83);
    frame("q0", bytes_v[0], 3, 9);
    for (int i = 1; i < 9; i++)
      next_frame($sformatf("q%0d", i), bytes_v[i], 3);
    chk("q end busy", 32'(busy), 32'd0);
    chk("q end tx", 32'(tx), 32'd1);
    rd("q end status", 2'd1, 32'h4);

    // DIV change mid-frame applies to next frame
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'hC3);
    wr(2'd2, 32'd1);
    frame("3c", 8'h3C, 3, 1);
    next_frame("c3", 8'hC3, 1);
    chk("c3 end busy", 32'(busy), 32'd0);

    // reset during data bit 4
    wr(2'd0, 32'hEF);
    wr(2'd0, 32'h12);
    wr(2'd0, 32'h34);
    repeat (9) @(negedge clk);
    chk("pre-rst tx", 32'(tx), 32'd0);
    rd("pre-rst status", 2'd1, 32'h21);
    rst = 1'b1;
    #1;
    chk("mid-rst tx", 32'(tx), 32'd1);
    rd("mid-rst status", 2'd1, 32'h4);
    rd("mid-rst div", 2'd2, 32'd433);
    chk("mid-rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post-rst low cycles", 32'(lows), 32'd0);
    chk("post-rst busy", 32'(busy), 32'd0);
    rd("post-rst status", 2'd1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
